// File: rtl/bitstream_loader.sv
// bitstream_loader: serial configuration master that shifts a parallel image LSB-first into the programming chain; the optional readback verify is enabled by BITSTREAM_LOADER_VERIFY_EN
module bitstream_loader #(
  parameter int CHAIN_LEN = 69,
  parameter int CNT_W = 8
) (
  input  logic                 prog_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] bitstream,
  input  logic                 prog_out,
  output logic                 prog_in,
  output logic                 prog_en,
  output logic                 busy,
  output logic                 done,
  output logic                 verify_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, VERIFY, DONE} state_t;
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
  state_t state, state_n;
  logic [CHAIN_LEN-1:0] shadow, shadow_n, rot;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic prog_in_n, prog_en_n, busy_n, done_n;
  assign rot = {shadow[0], shadow[CHAIN_LEN-1:1]};
`ifdef BITSTREAM_LOADER_VERIFY_EN
  localparam logic [CNT_W-1:0] VERIFY_LAST = CNT_W'(2 * CHAIN_LEN - 1);
  logic err_n;
`else
  logic unused;
  assign unused = prog_out;
  assign verify_err = 1'b0;
`endif
  // Next state and next registered outputs; the shadow rotates so bit 0 is always the bit on prog_in
  always_comb begin
    state_n = state;
    shadow_n = shadow;
    cnt_n = cnt;
    prog_in_n = 1'b0;
    prog_en_n = 1'b0;
    busy_n = busy;
    done_n = 1'b0;
`ifdef BITSTREAM_LOADER_VERIFY_EN
    err_n = verify_err;
`endif
    case (state)
      IDLE: if (start) begin
        state_n = SHIFT;
        shadow_n = bitstream;
        cnt_n = '0;
        prog_in_n = bitstream[0];
        prog_en_n = 1'b1;
        busy_n = 1'b1;
`ifdef BITSTREAM_LOADER_VERIFY_EN
        err_n = 1'b0;
`endif
      end
      SHIFT: begin
        shadow_n = rot;
        cnt_n = cnt + CNT_W'(1);
        if (cnt != SHIFT_LAST) begin
          prog_in_n = rot[0];
          prog_en_n = 1'b1;
        end else begin
`ifdef BITSTREAM_LOADER_VERIFY_EN
          state_n = VERIFY;
          prog_in_n = rot[0];
          prog_en_n = 1'b1;
`else
          state_n = DONE;
          busy_n = 1'b0;
          done_n = 1'b1;
`endif
        end
      end
`ifdef BITSTREAM_LOADER_VERIFY_EN
      VERIFY: begin
        shadow_n = rot;
        cnt_n = cnt + CNT_W'(1);
        err_n = verify_err | (prog_out != shadow[0]);
        if (cnt != VERIFY_LAST) begin
          prog_in_n = rot[0];
          prog_en_n = 1'b1;
        end else begin
          state_n = DONE;
          busy_n = 1'b0;
          done_n = 1'b1;
        end
      end
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge prog_clk) begin
    if (!rst) begin
      state <= IDLE;
      shadow <= '0;
      cnt <= '0;
      prog_in <= 1'b0;
      prog_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      shadow <= shadow_n;
      cnt <= cnt_n;
      prog_in <= prog_in_n;
      prog_en <= prog_en_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
`ifdef BITSTREAM_LOADER_VERIFY_EN
  // Sticky readback mismatch flag, cleared on accept or reset
  always_ff @(posedge prog_clk) verify_err <= !rst ? 1'b0 : err_n;
`endif
endmodule

// File: tb/tb_bitstream_loader.sv
// tb_bitstream_loader: table-driven check of bitstream_loader against a behavioural 69-flop chain
module tb_bitstream_loader;
  localparam int L = 69;
`ifdef BITSTREAM_LOADER_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int NE = VER ? 2 * L : L;
  typedef struct {
    logic [L-1:0] img;
    int hook;
    int exp_en;
    logic [L-1:0] exp_chain;
    logic exp_err;
  } vec_t;
  logic prog_clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [L-1:0] bitstream = '0;
  logic [L-1:0] chain = '0;
  logic [L-1:0] inj = '0;
  logic prog_out, prog_in, prog_en, busy, done, verify_err;
  int errors = 0;
  int checks = 0;
  int n_en, n_done, done_cyc;
  bit gap, busy_bad, pin_bad;
  string tag = "init";
  vec_t tbl[$];

  bitstream_loader #(.CHAIN_LEN(L), .CNT_W(8)) dut (
    .prog_clk(prog_clk), .rst(rst), .start(start), .bitstream(bitstream),
    .prog_out(prog_out), .prog_in(prog_in), .prog_en(prog_en),
    .busy(busy), .done(done), .verify_err(verify_err)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) chain <= (prog_en ? {prog_in, chain[L-1:1]} : chain) ^ inj;
  assign prog_out = chain[0];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h, expected %0h", tag, nm, act, exp);
    end
  endtask

  task automatic load(input logic [L-1:0] img, input int hook);
    bit fin = 1'b0;
    n_en = 0; n_done = 0; done_cyc = -1; gap = 0; busy_bad = 0; pin_bad = 0;
    @(negedge prog_clk); bitstream = img; start = 1'b1;
    @(negedge prog_clk); start = 1'b0; bitstream = ~img;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (hook == 3 && c == 41) begin
        chk("rst_en_drop", 128'(prog_en), 128'(0));
        chk("rst_busy_drop", 128'(busy), 128'(0));
        chk("rst_no_done", 128'(done), 128'(0));
        rst = 1'b1;
        fin = 1'b1;
      end else if (hook == 4 && done_cyc >= 0 && c == done_cyc + 1) begin
        chk("done_start_busy", 128'(busy), 128'(0));
        chk("done_start_en", 128'(prog_en), 128'(0));
      end else if (hook == 4 && done_cyc >= 0 && c == done_cyc + 2) begin
        chk("idle_accept_busy", 128'(busy), 128'(1));
        chk("idle_accept_en", 128'(prog_en), 128'(1));
        start = 1'b0;
        fin = 1'b1;
      end else begin
        if (busy !== ((done_cyc < 0) && !done)) busy_bad = 1'b1;
        if (prog_en) begin
          n_en++;
          if (done_cyc >= 0 || n_en != c + 1) gap = 1'b1;
        end else if (prog_in !== 1'b0) pin_bad = 1'b1;
        if (done) begin
          n_done++;
          if (done_cyc < 0) done_cyc = c;
        end
        if (hook == 1 && c == 30) start = 1'b1;
        if (hook == 1 && c == 31) start = 1'b0;
        if (hook == 2) inj = (c == L - 1) ? (L'(1) << 10) : '0;
        if (hook == 3 && c == 40) rst = 1'b0;
        if (hook == 4 && c == done_cyc) begin start = 1'b1; bitstream = img; end
        if (done_cyc >= 0 && c >= done_cyc + 3) fin = 1'b1;
      end
      @(negedge prog_clk);
    end
    if (hook == 4) begin
      for (int k = 0; k < 400 && !done; k++) @(negedge prog_clk);
      chk("reaccept_done", 128'(done), 128'(1));
      @(negedge prog_clk);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    tag = nm;
    load(v.img, v.hook);
    chk("en_cycles", 128'(n_en), 128'(v.exp_en));
    chk("done_cycle", 128'(done_cyc), 128'(v.exp_en));
    chk("done_pulses", 128'(n_done), 128'(1));
    chk("en_contiguous", 128'(gap), 128'(0));
    chk("busy_window", 128'(busy_bad), 128'(0));
    chk("prog_in_idle_zero", 128'(pin_bad), 128'(0));
    chk("chain", 128'(chain), 128'(v.exp_chain));
    chk("verify_err", 128'(verify_err), 128'(v.exp_err));
  endtask

  initial begin
    logic [L-1:0] basic, vimg, ones;
    logic [95:0] r;
    vec_t v;
    basic = 69'h0_1234_5678_9ABC_DEAA;
    vimg = 69'h1F_FFFF_0000_FFFF_0000;
    ones = '1;
    tbl.push_back('{basic, 0, NE, basic, 1'b0});
    tbl.push_back('{'0, 0, NE, '0, 1'b0});
    tbl.push_back('{vimg, 0, NE, vimg, 1'b0});
    tbl.push_back('{vimg, 0, NE, vimg, 1'b0});
    tbl.push_back('{basic, 1, NE, basic, 1'b0});
    tbl.push_back('{vimg, 2, NE, VER ? vimg : vimg ^ (L'(1) << 10), VER});
    tbl.push_back('{vimg, 0, NE, vimg, 1'b0});
    tbl.push_back('{basic, 4, NE, basic, 1'b0});
    for (int i = 0; i < 10; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      v.img = r[L-1:0];
      v.img[7:0] = 8'hAA;
      v.hook = 0; v.exp_en = NE; v.exp_chain = v.img; v.exp_err = 1'b0;
      tbl.push_back(v);
    end
    tag = "reset";
    repeat (3) @(negedge prog_clk);
    chk("prog_in", 128'(prog_in), 128'(0));
    chk("prog_en", 128'(prog_en), 128'(0));
    chk("busy", 128'(busy), 128'(0));
    chk("done", 128'(done), 128'(0));
    chk("verify_err", 128'(verify_err), 128'(0));
    tag = "rst_vs_start";
    start = 1'b1; bitstream = basic;
    @(negedge prog_clk);
    chk("busy", 128'(busy), 128'(0));
    chk("prog_en", 128'(prog_en), 128'(0));
    start = 1'b0; rst = 1'b1;
    @(negedge prog_clk);
    chk("busy_after", 128'(busy), 128'(0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));
    tag = "mid_reset";
    load(basic, 3);
    chk("done_pulses", 128'(n_done), 128'(0));
    repeat (3) @(negedge prog_clk);
    chk("busy_idle", 128'(busy), 128'(0));
    chk("en_idle", 128'(prog_en), 128'(0));
    apply('{ones, 0, NE, 69'h1F_FFFF_FFFF_FFFF_FFFF, 1'b0}, "reload_ones");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bitstream_loader.md
# bitstream_loader

- Serial configuration master for the fabric's programming chain.
- Accepts a full parallel bitstream image in one cycle, then shifts it LSB-first onto `prog_in` under `prog_en` into a daisy-chained shift register, such as a connection block's 69-bit chain.
- Optionally performs a non-destructive readback verify through the chain tail `prog_out`.
- Sits between the configuration controller and the first tile's `prog_in`.

## Interface
Parameters:
- `CHAIN_LEN`, default 69: number of configuration flops in the chain; also the bitstream width.
- `CNT_W`, default 8: bit counter width; must satisfy 2^CNT_W > 2*CHAIN_LEN.

Ports:
- `prog_clk` in 1: the single clock; the chain shares it.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: load request, sampled at posedge.
- `bitstream` in CHAIN_LEN: image to load; bit 0 is shifted first.
- `prog_out` in 1: chain tail, i.e. the registered output of the last chain flop.
- `prog_in` out 1: serial data to the chain head.
- `prog_en` out 1: chain shift enable.
- `busy` out 1: high from accept until the cycle `done` is asserted.
- `done` out 1: single-cycle completion pulse.
- `verify_err` out 1: sticky readback mismatch flag.

## Operation
- States: IDLE, SHIFT, VERIFY (macro only), DONE.
- IDLE: `start`=1 latches `bitstream` into a shadow register, clears `verify_err` and the counter, sets `busy`, and goes to SHIFT.
- SHIFT: each cycle drives `prog_in`=shadow[cnt] with `prog_en`=1, then increments `cnt`. After cnt reaches CHAIN_LEN-1, the next state is VERIFY if the macro is defined, otherwise DONE.
- VERIFY: re-shifts the same shadow image, bit j on `prog_in` as in SHIFT. Because the chain already holds the image, `prog_out` presents old bit j during the cycle bit j is driven. The loader compares `prog_out` to shadow[j] at that posedge; any mismatch sets `verify_err`. The final chain contents equal the image.
- DONE: `prog_en`=0, `done`=1 for one cycle, `busy`=0, then IDLE.
- `start` while `busy` is ignored; no queuing.
- `bitstream` changes after accept have no effect.
- `verify_err` holds until the next accepted `start` or reset.
- `prog_in` is 0 whenever `prog_en`=0.

## Timing
- All outputs are registered.
- Reset values: `prog_in`=0, `prog_en`=0, `busy`=0, `done`=0, `verify_err`=0. State is IDLE and the counter is 0.
- Start accepted at edge E0:
  - `prog_en` is high for edges E1..E_CHAIN_LEN and carries bit k-1 at edge E_k.
  - `done` is high in the cycle after E_CHAIN_LEN.
  - Load latency is CHAIN_LEN+1 cycles.
- With verify, `prog_en` stays high contiguously for 2*CHAIN_LEN edges with no bubble; latency is 2*CHAIN_LEN+1 cycles.
- `start` asserted in the DONE cycle is ignored. The earliest re-accept is the first IDLE cycle.
- `rst`=0 mid-shift: next edge drops `prog_en`, no `done` pulse, and the chain holds a partial image. Software must reload.
- `start` and `rst`=0 on the same edge: reset wins.

## Configuration
- Macro: `BITSTREAM_LOADER_VERIFY_EN`.
- Defined: the VERIFY state exists, `prog_out` is compared, and `verify_err` is live.
- Undefined: SHIFT goes directly to DONE, `prog_out` is unused, and `verify_err` is tied to 0.

## Test plan
The bench uses a behavioural 69-flop chain model, shifting on `prog_en`, with `prog_out` taken from the last flop.

- **Basic load.** After reset, `start` with bitstream = 69'h0_1234_5678_9ABC_DEAA (low byte 8'b10101010) -> `prog_en` high exactly 69 cycles, chain equals image, `done` one pulse at cycle 70, `busy` low after.
- **Verify pass, macro defined.** Load 69'h1F_FFFF_0000_FFFF_0000 twice -> `prog_en` high 138 contiguous cycles, `verify_err`=0, chain equals image.
- **Verify fail, macro defined.** Force chain flop 10 inverted after the first pass -> `verify_err`=1 after `done`; the next `start` clears it.
- **Busy ignore.** Pulse `start` with a different image at cycle 30 of a load -> ignored, chain holds the first image, only one `done` pulse.
- **Reset mid-shift.** Drive `rst`=0 at cycle 40 -> `prog_en`=0 at the next edge, `busy`=0, no `done`. A fresh load of all-ones then yields chain = 69'h1F_FFFF_FFFF_FFFF_FFFF.
- **Repeated random loads.** Ten back-to-back random images, each with low byte 8'hAA -> chain matches every image and `verify_err` stays 0 throughout.
